// File: rtl/rpn_exec.sv
// RPN calculator command sequencer: DEPTH-entry operand stack driving an external combinational ALU.
// Optional DUP/SWAP/DROP stack operations are enabled by defining RPN_STACKOPS_EN.
module rpn_exec #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_is_op,
  input  logic [7:0]                   cmd_data,
  input  logic [2:0]                   cmd_op,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic [2:0]                   alu_op,
  input  logic [7:0]                   alu_result,
  output logic [7:0]                   tos,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         done,
  output logic [1:0]                   err_code
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
`ifdef RPN_STACKOPS_EN
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_DROP = 3'b111;
`endif

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_UNF  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2} state_t;

  state_t          state_r;
  logic [7:0]      stack_r [DEPTH];
  logic [DW-1:0]   depth_r;
  logic [2:0]      op_r;
  logic [7:0]      alu_a_r;
  logic [7:0]      alu_b_r;
  logic [2:0]      alu_op_r;
  logic            ready_r;
  logic            done_r;
  logic [1:0]      err_r;
  logic [AW-1:0]   push_idx_s;
  logic [AW-1:0]   top_idx_s;
  logic [AW-1:0]   nos_idx_s;
  logic [7:0]      tos_s;

  // Index arithmetic is only consumed when the guarding depth check passes, so truncation is safe.
  assign push_idx_s = AW'(depth_r);
  assign top_idx_s  = AW'(depth_r - DW'(1));
  assign nos_idx_s  = AW'(depth_r - DW'(2));

  // Top-of-stack view, zero when the stack is empty.
  always_comb begin
    tos_s = 8'd0;
    if (depth_r != {DW{1'b0}}) begin
      tos_s = stack_r[top_idx_s];
    end else begin
      tos_s = 8'd0;
    end
  end

  // Sequencer FSM, stack storage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      depth_r  <= {DW{1'b0}};
      op_r     <= 3'd0;
      alu_a_r  <= 8'd0;
      alu_b_r  <= 8'd0;
      alu_op_r <= 3'd0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= ERR_NONE;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (!cmd_is_op) begin
              if (depth_r != DMAX) begin
                stack_r[push_idx_s] <= cmd_data;
                depth_r             <= depth_r + DW'(1);
                done_r              <= 1'b1;
                err_r               <= ERR_NONE;
              end else begin
                err_r <= ERR_OVF;
              end
            end else begin
              case (cmd_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  if (depth_r >= DW'(2)) begin
                    state_r <= FETCH;
                    ready_r <= 1'b0;
                    op_r    <= cmd_op;
                    err_r   <= ERR_NONE;
                  end else begin
                    err_r <= ERR_UNF;
                  end
                end
                OP_NOT: begin
                  if (depth_r != {DW{1'b0}}) begin
                    state_r <= FETCH;
                    ready_r <= 1'b0;
                    op_r    <= cmd_op;
                    err_r   <= ERR_NONE;
                  end else begin
                    err_r <= ERR_UNF;
                  end
                end
`ifdef RPN_STACKOPS_EN
                OP_DUP: begin
                  if (depth_r == {DW{1'b0}}) begin
                    err_r <= ERR_UNF;
                  end else if (depth_r == DMAX) begin
                    err_r <= ERR_OVF;
                  end else begin
                    stack_r[push_idx_s] <= stack_r[top_idx_s];
                    depth_r             <= depth_r + DW'(1);
                    done_r              <= 1'b1;
                    err_r               <= ERR_NONE;
                  end
                end
                OP_SWAP: begin
                  if (depth_r >= DW'(2)) begin
                    stack_r[top_idx_s] <= stack_r[nos_idx_s];
                    stack_r[nos_idx_s] <= stack_r[top_idx_s];
                    done_r             <= 1'b1;
                    err_r              <= ERR_NONE;
                  end else begin
                    err_r <= ERR_UNF;
                  end
                end
                OP_DROP: begin
                  if (depth_r != {DW{1'b0}}) begin
                    depth_r <= depth_r - DW'(1);
                    done_r  <= 1'b1;
                    err_r   <= ERR_NONE;
                  end else begin
                    err_r <= ERR_UNF;
                  end
                end
`endif
                default: err_r <= ERR_ILL;
              endcase
            end
          end
        end
        FETCH: begin
          // NOT takes TOS as operand A; binary ops take next-on-stack as A, TOS as B.
          if (op_r == OP_NOT) begin
            alu_a_r <= stack_r[top_idx_s];
            alu_b_r <= 8'd0;
          end else begin
            alu_a_r <= stack_r[nos_idx_s];
            alu_b_r <= stack_r[top_idx_s];
          end
          alu_op_r <= op_r;
          state_r  <= EXEC;
        end
        EXEC: begin
          if (op_r == OP_NOT) begin
            stack_r[top_idx_s] <= alu_result;
          end else begin
            stack_r[nos_idx_s] <= alu_result;
            depth_r            <= depth_r - DW'(1);
          end
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign tos       = tos_s;
  assign depth     = depth_r;
  assign done      = done_r;
  assign err_code  = err_r;

endmodule

// File: tb/tb_rpn_exec.sv
// Directed self-checking bench for rpn_exec with a behavioural 8-bit ALU model.
module tb_rpn_exec;

  localparam int D  = 8;
  localparam int DW = $clog2(D + 1);

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_is_op;
  logic [7:0]    cmd_data;
  logic [2:0]    cmd_op;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_op;
  logic [7:0]    alu_result;
  logic [7:0]    tos;
  logic [DW-1:0] depth;
  logic          done;
  logic [1:0]    err_code;

  int checks = 0;
  int fails  = 0;

  rpn_exec #(.DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_op(cmd_is_op), .cmd_data(cmd_data), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .tos(tos), .depth(depth), .done(done), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational ALU.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = ~alu_a;
      3'b100:  alu_result = alu_a | alu_b;
      default: alu_result = 8'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] v);
    cmd_valid = 1'b1; cmd_is_op = 1'b0; cmd_data = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op);
    cmd_valid = 1'b1; cmd_is_op = 1'b1; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_is_op = 1'b0; cmd_data = 8'd0; cmd_op = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_tos", 32'(tos), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);

    // 3 4 sub -> 0xFF, with cmd_* changed after acceptance
    do_push(8'd3);
    chk("push3_done", 32'(done), 32'd1);
    chk("push3_tos", 32'(tos), 32'd3);
    do_push(8'd4);
    chk("push4_depth", 32'(depth), 32'd2);
    do_op(3'b001);
    cmd_op = 3'b111; cmd_is_op = 1'b0; cmd_data = 8'hAA;
    chk("sub_fetch_ready", 32'(cmd_ready), 32'd0);
    chk("sub_fetch_done", 32'(done), 32'd0);
    tick();
    chk("sub_alu_a", 32'(alu_a), 32'd3);
    chk("sub_alu_b", 32'(alu_b), 32'd4);
    chk("sub_alu_op", 32'(alu_op), 32'd1);
    chk("sub_exec_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("sub_done", 32'(done), 32'd1);
    chk("sub_depth", 32'(depth), 32'd1);
    chk("sub_tos", 32'(tos), 32'hFF);
    chk("sub_ready_back", 32'(cmd_ready), 32'd1);
    tick();
    chk("sub_done_pulse", 32'(done), 32'd0);

    // 0xFF 1 add -> 0x00
    do_push(8'd1);
    do_op(3'b000);
    tick();
    tick();
    chk("add_wrap_tos", 32'(tos), 32'h00);
    chk("add_wrap_depth", 32'(depth), 32'd1);

    // unary NOT
    do_reset();
    do_push(8'h0F);
    do_op(3'b011);
    tick();
    chk("not_alu_a", 32'(alu_a), 32'h0F);
    chk("not_alu_b", 32'(alu_b), 32'h00);
    chk("not_alu_op", 32'(alu_op), 32'd3);
    tick();
    chk("not_tos", 32'(tos), 32'hF0);
    chk("not_depth", 32'(depth), 32'd1);
    chk("not_done", 32'(done), 32'd1);

    // underflow on empty stack, then recovery
    do_reset();
    do_op(3'b000);
    chk("unf_err", 32'(err_code), 32'd1);
    chk("unf_depth", 32'(depth), 32'd0);
    chk("unf_done", 32'(done), 32'd0);
    chk("unf_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("unf_err_hold", 32'(err_code), 32'd1);
    do_push(8'd5);
    chk("unf_clr_err", 32'(err_code), 32'd0);
    chk("unf_clr_tos", 32'(tos), 32'd5);

    // fill back-to-back, then overflow
    do_reset();
    cmd_valid = 1'b1; cmd_is_op = 1'b0;
    for (int i = 1; i <= D; i++) begin
      cmd_data = 8'(i);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_depth", 32'(depth), 32'(D));
    chk("full_tos", 32'(tos), 32'(D));
    do_push(8'd9);
    chk("ovf_err", 32'(err_code), 32'd2);
    chk("ovf_depth", 32'(depth), 32'(D));
    chk("ovf_tos", 32'(tos), 32'(D));
    chk("ovf_done", 32'(done), 32'd0);

    // reset during EXEC
    do_reset();
    do_push(8'd2);
    do_push(8'd6);
    do_op(3'b100);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rexec_depth", 32'(depth), 32'd0);
    chk("rexec_tos", 32'(tos), 32'd0);
    chk("rexec_alu", {8'd0, alu_a, alu_b, 5'd0, alu_op}, 32'd0);
    chk("rexec_ready", 32'(cmd_ready), 32'd1);
    chk("rexec_done", 32'(done), 32'd0);

    // stack operations
    do_push(8'd1);
    do_push(8'd2);
    do_op(3'b110);
`ifdef RPN_STACKOPS_EN
    chk("swap_tos", 32'(tos), 32'd1);
    chk("swap_done", 32'(done), 32'd1);
    do_op(3'b101);
    chk("dup_depth", 32'(depth), 32'd3);
    chk("dup_tos", 32'(tos), 32'd1);
    do_op(3'b111);
    chk("drop_depth", 32'(depth), 32'd2);
    chk("drop_tos", 32'(tos), 32'd1);
`else
    chk("ill_err", 32'(err_code), 32'd3);
    chk("ill_tos", 32'(tos), 32'd2);
    chk("ill_depth", 32'(depth), 32'd2);
    chk("ill_done", 32'(done), 32'd0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/rpn_exec.md
# rpn_exec

Command sequencer and operand stack for the RPN calculator datapath. It accepts push-value and operator commands one at a time over a valid/ready handshake and holds operands in a DEPTH-entry LIFO. For each operator it pops operands, drives the combinational 8-bit ALU's operand and opcode inputs from registers, captures the result and pushes it back. It is the initiator side of the ALU operand/opcode interface.

## Interface
- DEPTH, 8, number of stack entries; legal range 2..15
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; takes effect on the rising edge of clk
- cmd_valid  input  1  command present
- cmd_ready  output  1  high in IDLE only; a command is accepted on an edge where valid&&ready
- cmd_is_op  input  1  0 = push cmd_data, 1 = execute cmd_op
- cmd_data  input  8  value to push
- cmd_op  input  3  000 add, 001 sub, 010 and, 011 not, 100 or, 101..111 see Configuration
- alu_a  output  8  registered ALU operand A
- alu_b  output  8  registered ALU operand B
- alu_op  output  3  registered ALU opcode
- alu_result  input  8  combinational ALU output
- tos  output  8  current top of stack; 0 when empty
- depth  output  $clog2(DEPTH+1)  entries held
- done  output  1  one-cycle pulse per successfully completed command
- err_code  output  2  00 none, 01 underflow, 10 overflow, 11 illegal op

## Operation
- States: IDLE, FETCH, EXEC.
- Push, in IDLE:
  - depth<DEPTH: write cmd_data at index depth, depth+1, stay IDLE.
  - depth==DEPTH: overflow; stack unchanged.
- Binary op (000,001,010,100), in IDLE:
  - Requires depth>=2, else underflow; state stays IDLE.
  - Otherwise go to FETCH.
  - FETCH: alu_a<=entry[depth-2] (next-on-stack), alu_b<=entry[depth-1] (TOS), alu_op<=cmd_op; go to EXEC.
  - EXEC: entry[depth-2]<=alu_result, depth-1, return to IDLE.
- Unary op (011, NOT):
  - Requires depth>=1, else underflow.
  - FETCH: alu_a<=TOS, alu_b<=0.
  - EXEC: TOS<=alu_result; depth unchanged.
- cmd_op is latched on acceptance; later changes on the cmd_* inputs have no effect.
- Arithmetic wraps mod 256; no carry or flags.
  - "3 4 sub" leaves 0xFF.
  - "0xFF 1 add" leaves 0x00.
- Errors:
  - Command is consumed in one cycle, stack unchanged, no done pulse.
  - err_code is set on the rejecting edge.
  - err_code holds until the next accepted command, which overwrites it (00 on success).
- alu_a/alu_b/alu_op hold their last values outside FETCH.
- Reset, including mid-operation (FETCH/EXEC):
  - state<=IDLE, depth<=0, stack contents don't-care.
  - alu_a/alu_b/alu_op<=0, done<=0, err_code<=00, cmd_ready=1 after the edge.
- tos is combinational from entry[depth-1], forced to 0 when depth==0.

## Timing
- Push, stack op, or error:
  - Accepted at edge N.
  - done/err_code visible in cycle N..N+1.
  - cmd_ready stays high, so back-to-back acceptance is possible every cycle.
- ALU op:
  - Accepted at edge N; cmd_ready low during FETCH (N..N+1) and EXEC (N+1..N+2).
  - alu_* registered at edge N+1.
  - Result written at edge N+2.
  - done high N+2..N+3; cmd_ready high again after edge N+2.
  - Throughput: one op per 3 cycles.
- Depth and tos reflect a write from the edge it occurs.

## Configuration
- RPN_STACKOPS_EN defined:
  - 101 DUP: needs 1<=depth<DEPTH (else underflow/overflow); copies TOS.
  - 110 SWAP: needs depth>=2; exchanges the top two entries.
  - 111 DROP: needs depth>=1; depth-1.
  - All three are single-cycle in IDLE, do not touch the ALU, and pulse done.
- RPN_STACKOPS_EN undefined: 101..111 produce err_code 11, stack unchanged.

## Test plan
- Reset, then push 3, push 4, op 001 -> alu_a=3, alu_b=4, alu_op=001 one cycle after acceptance; after 3 cycles depth=1, tos=0xFF, done one pulse.
- Push 0x0F, op 011 -> alu_a=0x0F, alu_b=0; tos=0xF0, depth=1.
- Empty stack, op 000 -> err_code=01, depth=0, no done, cmd_ready stays high; next push 5 -> err_code=00, tos=5.
- Push DEPTH values 1..DEPTH back-to-back (one per cycle), then push 9 -> err_code=10, depth=DEPTH, tos=DEPTH.
- Push 2, push 6, op 100, assert reset during EXEC -> depth=0, tos=0, alu_*=0, cmd_ready=1, no done.
- With RPN_STACKOPS_EN: push 1, push 2, op 110 -> tos=1; op 101 -> depth=3, tos=1. Without it: op 110 -> err_code=11, tos=2.
